// File: rtl/fft_result_sink.sv
// AXI4-Stream sink for FFT result frames: ping-pong buffer of 2 x TRANSFORM_LENGTH words with
// tlast framing checks. Define FFT_SINK_BITREV_EN to store samples at bit-reversed addresses.
module fft_result_sink #(
    parameter int TRANSFORM_LENGTH = 16,
    parameter int DATA_WIDTH       = 32,
    localparam int AW              = $clog2(TRANSFORM_LENGTH)
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_axis_data_tdata,
    input  logic                  s_axis_data_tvalid,
    output logic                  s_axis_data_tready,
    input  logic                  s_axis_data_tlast,
    output logic                  frame_ready,
    input  logic                  frame_ack,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  err_tlast_early,
    output logic                  err_tlast_missing,
    output logic [15:0]           frame_count
);

    localparam logic [AW-1:0] LAST_IDX = AW'(TRANSFORM_LENGTH - 1);

    typedef enum logic {StFill, StFullWait} state_e;

    state_e                r_state;
    logic                  r_tready;
    logic [AW-1:0]         r_widx;
    logic                  r_wbank;
    logic                  r_rbank;
    logic [1:0]            r_full_cnt;
    logic [15:0]           r_frame_count;
    logic                  r_err_early;
    logic                  r_err_missing;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [DATA_WIDTH-1:0] r_mem [0:2*TRANSFORM_LENGTH-1];

    logic                  w_xfer;
    logic                  w_pub;
    logic                  w_ack;
    logic [1:0]            w_full_next;
    logic [AW-1:0]         w_waddr;

    assign w_xfer      = s_axis_data_tvalid & r_tready;
    assign w_pub       = w_xfer & (r_widx == LAST_IDX);
    assign w_ack       = frame_ack & (r_full_cnt != 2'd0);
    assign w_full_next = r_full_cnt + {1'b0, w_pub} - {1'b0, w_ack};

`ifdef FFT_SINK_BITREV_EN
    always_comb begin
        w_waddr = '0;
        for (int b = 0; b < AW; b++) begin
            w_waddr[b] = r_widx[AW-1-b];
        end
    end
`else
    assign w_waddr = r_widx;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= StFill;
            r_tready      <= 1'b0;
            r_widx        <= '0;
            r_wbank       <= 1'b0;
            r_rbank       <= 1'b0;
            r_full_cnt    <= 2'd0;
            r_frame_count <= 16'd0;
            r_err_early   <= 1'b0;
            r_err_missing <= 1'b0;
        end else begin
            r_err_early   <= 1'b0;
            r_err_missing <= 1'b0;
            if (w_pub) begin
                r_widx        <= '0;
                r_wbank       <= ~r_wbank;
                r_frame_count <= r_frame_count + 16'd1;
                r_err_missing <= ~s_axis_data_tlast;
            end else if (w_xfer && s_axis_data_tlast) begin
                // Early tlast: drop the partial frame and refill the same bank.
                r_widx      <= '0;
                r_err_early <= 1'b1;
            end else if (w_xfer) begin
                r_widx <= r_widx + 1'b1;
            end
            if (w_ack) begin
                r_rbank <= ~r_rbank;
            end
            r_full_cnt <= w_full_next;
            unique case (r_state)
                StFill: begin
                    if (w_full_next == 2'd2) begin
                        r_state  <= StFullWait;
                        r_tready <= 1'b0;
                    end else begin
                        r_tready <= 1'b1;
                    end
                end
                StFullWait: begin
                    if (w_ack) begin
                        r_state  <= StFill;
                        r_tready <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= StFill;
                    r_tready <= 1'b0;
                end
            endcase
        end
    end

    // Memory kept reset-free so it maps onto a simple dual-port RAM.
    always_ff @(posedge aclk) begin
        if (w_xfer) begin
            r_mem[{r_wbank, w_waddr}] <= s_axis_data_tdata;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[{r_rbank, rd_addr}];
        end
    end

    assign s_axis_data_tready = r_tready;
    assign frame_ready        = (r_full_cnt != 2'd0);
    assign rd_data            = r_rd_data;
    assign err_tlast_early    = r_err_early;
    assign err_tlast_missing  = r_err_missing;
    assign frame_count        = r_frame_count;

endmodule
